// File: rtl/ex_dispatch.sv
// ex_dispatch: execute-stage issue controller.
// Accepts one decoded operation at a time from ID and launches it on the
// adder, multiplier, divider or logic unit. It also tracks multi-cycle
// completion and drives the registered one-hot result select together with
// the write-back valid and tag. ID is stalled while a mul/div is in flight.
module ex_dispatch #(
    parameter int MUL_LATENCY = 2,
    parameter int TAG_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [3:0]           id_unit,
    input  logic [TAG_WIDTH-1:0] id_tag,
    input  logic                 flush,
    output logic                 mul_start,
    output logic                 div_start,
    input  logic                 div_done,
    output logic                 div_abort,
    output logic [3:0]           sel,
    output logic                 wb_valid,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic                 illegal,
    output logic                 busy
);

    localparam logic [3:0] UNIT_ADD = 4'b0001;
    localparam logic [3:0] UNIT_MUL = 4'b0010;
    localparam logic [3:0] UNIT_DIV = 4'b0100;
    localparam logic [3:0] UNIT_LOG = 4'b1000;
    localparam logic [3:0] MUL_CNT  = 4'(MUL_LATENCY);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic [TAG_WIDTH-1:0] op_tag_reg, op_tag_next;

    logic                 mul_start_reg, mul_start_next;
    logic                 div_start_reg, div_start_next;
    logic                 div_abort_reg, div_abort_next;
    logic [3:0]           sel_reg, sel_next;
    logic                 wb_valid_reg, wb_valid_next;
    logic [TAG_WIDTH-1:0] wb_tag_reg, wb_tag_next;
    logic                 illegal_reg, illegal_next;

    logic accept;
    logic mul_finish;
    logic div_finish;

    assign id_ready = (state_reg == IDLE) & ~flush;
    assign accept   = id_valid & id_ready;

    // The multiplier result is due once the countdown has reached 1.
    assign mul_finish = (state_reg == MUL_WAIT) && (cnt_reg <= 4'd1);
    // A div_done that coincides with div_start belongs to an earlier divide.
    assign div_finish = (state_reg == DIV_WAIT) && div_done && !div_start_reg;

    assign busy      = (state_reg != IDLE);
    assign mul_start = mul_start_reg;
    assign div_start = div_start_reg;
    assign div_abort = div_abort_reg;
    assign sel       = sel_reg;
    assign wb_valid  = wb_valid_reg;
    assign wb_tag    = wb_tag_reg;
    assign illegal   = illegal_reg;

    // State, counter and all registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            op_tag_reg    <= '0;
            mul_start_reg <= 1'b0;
            div_start_reg <= 1'b0;
            div_abort_reg <= 1'b0;
            sel_reg       <= 4'b0000;
            wb_valid_reg  <= 1'b0;
            wb_tag_reg    <= '0;
            illegal_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_tag_reg    <= op_tag_next;
            mul_start_reg <= mul_start_next;
            div_start_reg <= div_start_next;
            div_abort_reg <= div_abort_next;
            sel_reg       <= sel_next;
            wb_valid_reg  <= wb_valid_next;
            wb_tag_reg    <= wb_tag_next;
            illegal_reg   <= illegal_next;
        end
    end

    // Next state, countdown and latched tag; flush overrides everything.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_tag_next = op_tag_reg;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && id_unit == UNIT_MUL) begin
                        state_next  = MUL_WAIT;
                        cnt_next    = MUL_CNT;
                        op_tag_next = id_tag;
                    end else if (accept && id_unit == UNIT_DIV) begin
                        state_next  = DIV_WAIT;
                        op_tag_next = id_tag;
                    end
                end
                MUL_WAIT: begin
                    if (mul_finish) begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                DIV_WAIT: begin
                    if (div_finish) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    // Next values of the pulses, select and write-back tag; sel/tag hold otherwise.
    always_comb begin
        mul_start_next = 1'b0;
        div_start_next = 1'b0;
        div_abort_next = 1'b0;
        wb_valid_next  = 1'b0;
        illegal_next   = 1'b0;
        sel_next       = sel_reg;
        wb_tag_next    = wb_tag_reg;
        if (flush) begin
            div_abort_next = (state_reg == DIV_WAIT);
        end else if (accept) begin
            if (!$onehot(id_unit)) begin
                // Not a real unit: complete at once with a zero result.
                wb_valid_next = 1'b1;
                illegal_next  = 1'b1;
                sel_next      = 4'b0000;
                wb_tag_next   = id_tag;
            end else if (id_unit == UNIT_MUL) begin
                mul_start_next = 1'b1;
            end else if (id_unit == UNIT_DIV) begin
                div_start_next = 1'b1;
            end else if (id_unit == UNIT_ADD || id_unit == UNIT_LOG) begin
                wb_valid_next = 1'b1;
                sel_next      = id_unit;
                wb_tag_next   = id_tag;
            end
        end else if (mul_finish) begin
            wb_valid_next = 1'b1;
            sel_next      = UNIT_MUL;
            wb_tag_next   = op_tag_reg;
        end else if (div_finish) begin
            wb_valid_next = 1'b1;
            sel_next      = UNIT_DIV;
            wb_tag_next   = op_tag_reg;
        end
    end

endmodule

// File: tb/tb_ex_dispatch.sv
// Testbench for ex_dispatch: random operation stream checked every cycle
// against a timeline model (scheduled pulses per absolute cycle number),
// followed by a directed asynchronous-reset check during a multiply.
module tb_ex_dispatch;

    localparam int ML   = 3;
    localparam int TW   = 5;
    localparam int NCYC = 1500;
    localparam int ASZ  = NCYC + 40;
    localparam int BIG  = 1 << 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic          id_ready;
    logic [3:0]    id_unit;
    logic [TW-1:0] id_tag;
    logic          flush;
    logic          mul_start;
    logic          div_start;
    logic          div_done;
    logic          div_abort;
    logic [3:0]    sel;
    logic          wb_valid;
    logic [TW-1:0] wb_tag;
    logic          illegal;
    logic          busy;

    always #5 clk = ~clk;

    ex_dispatch #(.MUL_LATENCY(ML), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_unit(id_unit), .id_tag(id_tag),
        .flush(flush),
        .mul_start(mul_start), .div_start(div_start),
        .div_done(div_done), .div_abort(div_abort),
        .sel(sel), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .illegal(illegal), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    // Expected per-cycle events, indexed by absolute cycle number.
    bit            e_wb  [ASZ];
    bit            e_ill [ASZ];
    bit            e_mul [ASZ];
    bit            e_div [ASZ];
    bit            e_abt [ASZ];
    logic [3:0]    e_sel [ASZ];
    logic [TW-1:0] e_tag [ASZ];

    task automatic sched_wb(input int c, input logic [3:0] s, input logic [TW-1:0] t, input bit il);
        e_wb[c]  = 1'b1;
        e_sel[c] = s;
        e_tag[c] = t;
        e_ill[c] = il;
    endtask

    // Model: DUT can accept from cycle free_at on; pend_* describes the op in flight.
    int            free_at;
    int            pend_kind;   // 0 none, 1 mul, 2 div
    int            pend_wb;
    int            div_start_cyc;
    logic [TW-1:0] pend_tag;
    logic [3:0]    cur_sel;
    logic [TW-1:0] cur_tag;

    initial begin
        logic          f, v, dd, inflight;
        logic [3:0]    u;
        logic [TW-1:0] t;

        rst = 1'b1; id_valid = 1'b0; id_unit = 4'b0; id_tag = '0; flush = 1'b0; div_done = 1'b0;
        free_at = 0; pend_kind = 0; pend_wb = 0; div_start_cyc = 0; pend_tag = '0;
        cur_sel = 4'b0; cur_tag = '0;

        @(negedge clk);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_wb_tag", 32'(wb_tag), 32'h0);
        chk("rst_mul_start", 32'(mul_start), 32'h0);
        chk("rst_div_start", 32'(div_start), 32'h0);
        chk("rst_div_abort", 32'(div_abort), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_id_ready", 32'(id_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            f  = ($urandom_range(0, 15) == 0);
            v  = ($urandom_range(0, 2) != 0);
            dd = ($urandom_range(0, 3) == 0);
            t  = TW'($urandom);
            case ($urandom_range(0, 7))
                0: u = 4'b0001;
                1: u = 4'b1000;
                2: u = 4'b0010;
                3: u = 4'b0100;
                4: u = 4'b0010;
                5: u = 4'b0100;
                default: u = 4'($urandom);
            endcase
            id_valid = v; id_unit = u; id_tag = t; flush = f; div_done = dd;

            @(negedge clk);
            if (e_wb[cyc]) begin
                cur_sel = e_sel[cyc];
                cur_tag = e_tag[cyc];
            end
            inflight = (cyc < free_at);
            chk("id_ready", 32'(id_ready), 32'(!inflight && !f));
            chk("busy", 32'(busy), 32'(inflight));
            chk("wb_valid", 32'(wb_valid), 32'(e_wb[cyc]));
            chk("illegal", 32'(illegal), 32'(e_ill[cyc]));
            chk("mul_start", 32'(mul_start), 32'(e_mul[cyc]));
            chk("div_start", 32'(div_start), 32'(e_div[cyc]));
            chk("div_abort", 32'(div_abort), 32'(e_abt[cyc]));
            chk("sel", 32'(sel), 32'(cur_sel));
            chk("wb_tag", 32'(wb_tag), 32'(cur_tag));

            if (inflight) begin
                if (f) begin
                    if (pend_kind == 2) e_abt[cyc+1] = 1'b1;
                    if (pend_kind == 1) begin
                        e_wb[pend_wb]  = 1'b0;
                        e_ill[pend_wb] = 1'b0;
                    end
                    pend_kind = 0;
                    free_at   = cyc + 1;
                end else if (pend_kind == 2 && dd && cyc > div_start_cyc) begin
                    sched_wb(cyc + 1, 4'b0100, pend_tag, 1'b0);
                    pend_kind = 0;
                    free_at   = cyc + 1;
                end
            end else if (!f && v) begin
                if ($countones(u) != 1) begin
                    sched_wb(cyc + 1, 4'b0000, t, 1'b1);
                    free_at = cyc + 1;
                end else if (u == 4'b0010) begin
                    e_mul[cyc+1] = 1'b1;
                    pend_wb   = cyc + 1 + ML;
                    sched_wb(pend_wb, 4'b0010, t, 1'b0);
                    pend_kind = 1;
                    free_at   = pend_wb;
                end else if (u == 4'b0100) begin
                    e_div[cyc+1]  = 1'b1;
                    div_start_cyc = cyc + 1;
                    pend_tag      = t;
                    pend_kind     = 2;
                    free_at       = BIG;
                end else begin
                    sched_wb(cyc + 1, u, t, 1'b0);
                    free_at = cyc + 1;
                end
            end
            @(posedge clk); #1;
        end

        // Directed: asynchronous reset in the middle of a multiply.
        id_valid = 1'b0; div_done = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; id_valid = 1'b1; id_unit = 4'b0010; id_tag = TW'(7);
        @(negedge clk);
        chk("ar_ready_before", 32'(id_ready), 32'h1);
        @(posedge clk); #1;
        id_valid = 1'b0;
        @(negedge clk);
        chk("ar_mul_start", 32'(mul_start), 32'h1);
        chk("ar_busy_before", 32'(busy), 32'h1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_id_ready", 32'(id_ready), 32'h1);
        chk("ar_sel", 32'(sel), 32'h0);
        chk("ar_wb_tag", 32'(wb_tag), 32'h0);
        chk("ar_wb_valid", 32'(wb_valid), 32'h0);
        chk("ar_mul_start0", 32'(mul_start), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < ML + 3; i++) begin
            @(negedge clk);
            chk("ar_no_wb", 32'(wb_valid), 32'h0);
            chk("ar_idle", 32'(busy), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_dispatch.md
# ex_dispatch

Execute-stage issue controller that accepts decoded operations from ID, launches them on the adder, multiplier, divider or logic unit, and tracks multi-cycle completion. It drives the one-hot unit select consumed by the EX result multiplexer, together with a write-back valid and destination tag. It stalls ID while a multiplier or divider operation is in flight and supports pipeline flush.

## Interface
Parameters:
- MUL_LATENCY, 2: cycles from mul_start to multiplier result valid; legal range 1..15.
- TAG_WIDTH, 5: destination register tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID presents an operation.
- id_ready  out  1  dispatcher accepts; combinational, equals (state==IDLE) & ~flush.
- id_unit  in  4  one-hot unit code: 0001 add, 0010 mul, 0100 div, 1000 logic.
- id_tag  in  TAG_WIDTH  destination tag.
- flush  in  1  synchronous cancel of any in-flight operation.
- mul_start  out  1  one-cycle pulse launching the multiplier.
- div_start  out  1  one-cycle pulse launching the divider.
- div_done  in  1  divider completion pulse.
- div_abort  out  1  one-cycle pulse cancelling the divider.
- sel  out  4  registered one-hot select to the result multiplexer.
- wb_valid  out  1  one-cycle pulse: the result selected by sel is valid.
- wb_tag  out  TAG_WIDTH  tag accompanying wb_valid.
- illegal  out  1  one-cycle pulse: accepted id_unit was not one-hot.
- busy  out  1  state != IDLE.

## Operation
- Accept = id_valid & id_ready, sampled at a rising edge. The tag and unit are latched on accept.
- State machine has three states: IDLE, MUL_WAIT, DIV_WAIT. Reset state is IDLE.
- IDLE, accept add (0001) or logic (1000):
  - Next cycle: wb_valid=1, sel=id_unit, wb_tag=id_tag.
  - State stays IDLE, so back-to-back single-cycle operations sustain one per cycle.
- IDLE, accept mul (0010):
  - Next cycle: mul_start=1, counter loaded with MUL_LATENCY, state becomes MUL_WAIT.
  - The counter decrements each cycle in MUL_WAIT. When it reaches 1, the next cycle gives wb_valid=1, sel=0010, and state IDLE.
- IDLE, accept div (0100):
  - Next cycle: div_start=1, state becomes DIV_WAIT.
  - div_done is sampled from the cycle after div_start onward; div_done coincident with div_start is ignored.
  - On div_done=1: next cycle gives wb_valid=1, sel=0100, and state IDLE.
- IDLE, accept with id_unit not one-hot (0000, or more than one bit set):
  - Next cycle: wb_valid=1, illegal=1, sel=0000 (the multiplexer outputs zero), wb_tag=id_tag.
  - No unit is started.
- sel holds its last value between write-backs. wb_tag also holds its last value.
- div_done while in IDLE or MUL_WAIT is ignored; this covers stale completions after a flush.
- flush has the highest priority:
  - State goes to IDLE and the counter clears.
  - No wb_valid is produced for the cancelled operation, including one that would have fired in the next cycle.
  - If the state was DIV_WAIT: div_abort=1 in the next cycle.
  - No accept occurs in a flush cycle, because id_ready=0.
- Only one of wb_valid, mul_start or div_start pulses per cycle, except that wb_valid and the next launch never overlap. The next operation is accepted no earlier than the wb_valid cycle.

## Timing
- Reset values: sel=0000, wb_valid=0, wb_tag=0, mul_start=0, div_start=0, div_abort=0, illegal=0, busy=0.
- id_ready=1 after reset, provided flush=0.
- Reset asserted mid-operation clears all registers immediately; no pulse completes.
- Latency, with accept at edge 0:
  - add/logic: wb_valid in cycle 1.
  - mul: mul_start in cycle 1, wb_valid in cycle 1+MUL_LATENCY.
  - div: div_start in cycle 1; if div_done is high in cycle k (k≥2), wb_valid is in cycle k+1.
- id_ready returns to 1 in the same cycle as the multi-cycle wb_valid, so a new accept is possible at the end of that cycle.
- busy=1 from the cycle after a mul/div accept until, but excluding, the cycle of its wb_valid.
- Counter width is 4 bits. There is no wrap: the counter is only loaded in IDLE and only decremented in MUL_WAIT.

## Test plan
- Back-to-back add tag 3, then logic tag 4 -> wb_valid in cycles 1 and 2; sel 0001 then 1000; wb_tag 3 then 4; id_ready constantly 1.
- mul tag 7 with MUL_LATENCY=2 -> mul_start in cycle 1, id_ready=0 in cycles 1-2, wb_valid with sel=0010 and wb_tag=7 in cycle 3.
- div tag 9, div_done in cycle 1 and again in cycle 6 -> the cycle-1 pulse is ignored; wb_valid with sel=0100 in cycle 7; busy=1 in cycles 1-6.
- div in flight, flush in cycle 3, then stray div_done in cycle 5 -> div_abort in cycle 4, no wb_valid, state IDLE; the cycle-5 div_done is ignored.
- id_unit=0110, tag 2 -> cycle 1: wb_valid=1, illegal=1, sel=0000, no mul_start/div_start.
- Reset asserted asynchronously in MUL_WAIT mid-cycle -> all outputs go to reset values before the next edge; id_ready=1; no later wb_valid.
